// File: rtl/melody_pkg.sv
// Shared types, constants and field helpers for the melody sequencer.

`ifndef MELODY_PKG_MACROS
`define MELODY_PKG_MACROS
// Slice the note field out of a {note, dur} ROM word.
`define MELODY_NOTE(word, note_w, dur_w) word[(note_w)+(dur_w)-1 -: (note_w)]
// Slice the duration field out of a {note, dur} ROM word.
`define MELODY_DUR(word, dur_w) word[(dur_w)-1:0]
`endif

package melody_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Note index that silences the tone generator.
  localparam int unsigned NOTE_REST = 0;

  // Counter must hold both a full duration and the articulation gap.
  function automatic int unsigned cnt_width(input int unsigned dur_w,
                                            input int unsigned gap_ms);
    int unsigned gap_w;
    gap_w = $clog2(gap_ms + 1);
    return (gap_w > dur_w) ? gap_w : dur_w;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Single-bit synchronous rising-edge detector.

module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  // High for the one cycle where d has just gone from 0 to 1.
  always_comb begin
    rise = d & ~d_q;
  end

endmodule

// File: rtl/melody_sequencer.sv
// Walks a {note, dur} song ROM, timing each note in 1 ms ticks and inserting
// a silent articulation gap after every note.

module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 10,
  parameter int unsigned GAP_MS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_1ms,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic                    loop,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    note_start,
  output logic                    playing,
  output logic                    done
);

  localparam int unsigned     CNT_W     = cnt_width(DUR_W, GAP_MS);
  localparam logic [CNT_W-1:0]  GAP_CNT   = CNT_W'(GAP_MS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [NOTE_W-1:0] REST      = NOTE_W'(NOTE_REST);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              note_start_q, note_start_d;
  logic              done_q, done_d;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              tick_raw;
  logic              tick;
  logic              advance;
  logic              end_song;

  // 1 ms tick: rising edge of the divided clock, sampled in the system domain.
  edge_detect_rise u_tick_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (clk_1ms),
    .rise (tick_raw)
  );

  // Split the ROM word and qualify ticks: only count while timing and not paused.
  always_comb begin
    rom_note = `MELODY_NOTE(rom_data, NOTE_W, DUR_W);
    rom_dur  = `MELODY_DUR(rom_data, DUR_W);
    tick     = tick_raw & ~pause & ((state_q == ST_PLAY) || (state_q == ST_GAP));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update: stop overrides everything, then the
  // per-state action, then the shared advance / end-of-song resolution.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    note_d       = note_q;
    cnt_d        = cnt_q;
    note_start_d = 1'b0;
    done_d       = 1'b0;
    advance      = 1'b0;
    end_song     = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      note_d  = REST;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end
        end

        // Registered ROM needs one cycle for the word at addr_q to appear.
        ST_FETCH: begin
          state_d = ST_LOAD;
        end

        ST_LOAD: begin
          if (rom_dur == '0) begin
            end_song = 1'b1;
          end else begin
            note_d       = rom_note;
            cnt_d        = CNT_W'(rom_dur);
            note_start_d = 1'b1;
            state_d      = ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (tick) begin
            if (cnt_q == CNT_ONE) begin
              if (GAP_MS > 0) begin
                note_d  = REST;
                cnt_d   = GAP_CNT;
                state_d = ST_GAP;
              end else begin
                advance = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end

        ST_GAP: begin
          if (tick) begin
            if (cnt_q == CNT_ONE) begin
              advance = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Running off the last ROM word ends the song just like a dur==0 word.
      if (advance) begin
        if (addr_q == ADDR_LAST) begin
          end_song = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_FETCH;
        end
      end

      if (end_song) begin
        if (loop) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end else begin
          note_d  = REST;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Datapath registers: address, current note, ms counter and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      note_q       <= REST;
      cnt_q        <= '0;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      note_q       <= note_d;
      cnt_q        <= cnt_d;
      note_start_q <= note_start_d;
      done_q       <= done_d;
    end
  end

  // Outputs: everything registered except playing, decoded from the state.
  always_comb begin
    rom_addr   = addr_q;
    note       = note_q;
    note_start = note_start_q;
    done       = done_q;
    playing    = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: table-driven songs, randomized
// songs with random pause against a tick-level reference model, and
// hand-written sequences for loop, stop, pause, latency and reset.

module tb_melody_sequencer;

  localparam int ADDR_W = 4;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 10;
  localparam int GAP    = 2;
  localparam int WORDS  = 16;
  localparam int MS_DIV = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_1ms = 1'b0;
  logic              start, stop, pause, loop;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [NOTE_W-1:0] note;
  logic              note_start, playing, done;

  logic [15:0] rom [WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  int ms_edges  = 0;
  int ns_cnt    = 0;
  int done_cnt  = 0;
  int done_addr = -1;
  int samples[$];
  int ns_notes[$];

  // Reference model results.
  int model_q[$];
  int model_starts;
  int model_addr;

  typedef struct {
    logic [3:0][15:0] words;
    int               n_words;
    logic [15:0]      fill;
    int               exp_starts;
    int               exp_addr;
  } vec_t;

  vec_t vecs[4];

  melody_sequencer #(
    .ADDR_W (ADDR_W),
    .NOTE_W (NOTE_W),
    .DUR_W  (DUR_W),
    .GAP_MS (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_1ms    (clk_1ms),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop       (loop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .note_start (note_start),
    .playing    (playing),
    .done       (done)
  );

  initial forever #5 clk = ~clk;

  // Registered song ROM.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Divided 1 ms clock plus event monitor. One sample of note is taken just
  // before every unpaused tick: the value held during that millisecond.
  initial begin
    int mcnt;
    mcnt = 0;
    forever begin
      @(negedge clk);
      if (note_start) begin
        ns_cnt++;
        ns_notes.push_back(int'(note));
      end
      if (done) begin
        done_cnt++;
        done_addr = int'(rom_addr);
      end
      mcnt = (mcnt + 1) % MS_DIV;
      if (mcnt < MS_DIV / 2 && !clk_1ms) begin
        ms_edges++;
        if (!pause) samples.push_back(int'(note));
      end
      clk_1ms = (mcnt < MS_DIV / 2);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] w(input int n, input int d);
    logic [5:0] nn;
    logic [9:0] dd;
    nn = n[5:0];
    dd = d[9:0];
    return {nn, dd};
  endfunction

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < WORDS; i++) begin
      if (i < v.n_words) rom[i] = v.words[i[1:0]];
      else rom[i] = v.fill;
    end
  endtask

  // Expected millisecond-by-millisecond note sequence from the ROM contents.
  task automatic build_model();
    int addr, dur, nt;
    logic [15:0] word;
    model_q.delete();
    model_starts = 0;
    addr = 0;
    for (int k = 0; k < WORDS; k++) begin
      word = rom[addr];
      dur  = int'(word[9:0]);
      nt   = int'(word[15:10]);
      if (dur == 0) break;
      model_starts++;
      for (int t = 0; t < dur; t++) model_q.push_back(nt);
      for (int t = 0; t < GAP; t++) model_q.push_back(0);
      if (addr == WORDS - 1) break;
      addr++;
    end
    model_addr = addr;
    while (model_q.size() > 0 && model_q[$] == 0) void'(model_q.pop_back());
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  // Play the loaded ROM once (loop=0) and compare against the model.
  task automatic run_song(input bit rnd_pause, input int budget, input string tag,
                          input int exp_starts, input bit use_exp);
    int s0, n0, d0, cyc, mism;
    int q[$];
    s0 = samples.size();
    n0 = ns_cnt;
    d0 = done_cnt;
    loop = 1'b0;
    pulse_start();
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (rnd_pause && $urandom_range(0, 7) == 0) pause = ~pause;
    end
    pause = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int i = s0; i < samples.size(); i++) q.push_back(samples[i]);
    while (q.size() > 0 && q[0] == 0) void'(q.pop_front());
    while (q.size() > 0 && q[$] == 0) void'(q.pop_back());
    build_model();
    check({tag, "_len"}, q.size(), model_q.size());
    mism = 0;
    for (int i = 0; i < q.size() && i < model_q.size(); i++) begin
      if (q[i] != model_q[i]) mism++;
    end
    check({tag, "_seq_mismatches"}, mism, 0);
    check({tag, "_note_starts"}, ns_cnt - n0, use_exp ? exp_starts : model_starts);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_done_addr"}, done_addr, model_addr);
    check({tag, "_playing_after"}, int'(playing), 0);
  endtask

  initial begin
    int n0, d0, cyc, base, n;
    int exp4[4];
    exp4 = '{1, 2, 1, 2};

    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
    for (int i = 0; i < WORDS; i++) rom[i] = '0;

    for (int i = 0; i < 4; i++) begin
      vecs[i].words = '0;
      vecs[i].fill  = '0;
    end
    vecs[0].words[0] = w(5, 3); vecs[0].words[1] = w(0, 0);
    vecs[0].n_words = 2; vecs[0].exp_starts = 1;  vecs[0].exp_addr = 1;
    vecs[1].words[0] = w(1, 2); vecs[1].words[1] = w(2, 1); vecs[1].words[2] = w(0, 0);
    vecs[1].n_words = 3; vecs[1].exp_starts = 2;  vecs[1].exp_addr = 2;
    vecs[2].fill = w(7, 1);
    vecs[2].n_words = 0; vecs[2].exp_starts = 16; vecs[2].exp_addr = 15;
    vecs[3].words[0] = w(3, 0);
    vecs[3].n_words = 1; vecs[3].exp_starts = 0;  vecs[3].exp_addr = 0;

    // Reset values.
    #23;
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_note", int'(note), 0);
    check("rst_note_start", int'(note_start), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Start and stop together in IDLE: stays idle.
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    check("start_stop_idle_playing", int'(playing), 0);

    // Table-driven songs.
    for (int v = 0; v < 4; v++) begin
      load_vec(vecs[v]);
      run_song(1'b0, 3000, $sformatf("vec%0d", v), vecs[v].exp_starts, 1'b1);
      check($sformatf("vec%0d_table_addr", v), done_addr, vecs[v].exp_addr);
    end

    // Random songs with random pause.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < WORDS; i++) rom[i] = '0;
      for (int i = 0; i < n; i++) rom[i] = w($urandom_range(1, 63), $urandom_range(1, 4));
      run_song(1'b1, 6000, $sformatf("rnd%0d", r), 0, 1'b0);
    end

    // Loop: two-note song repeats, no done.
    load_vec(vecs[1]);
    n0 = ns_notes.size();
    d0 = done_cnt;
    loop = 1'b1;
    pulse_start();
    cyc = 0;
    while (ns_notes.size() < n0 + 4 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("loop_four_starts", int'(ns_notes.size() - n0 >= 4), 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("loop_note%0d", k),
            (n0 + k < ns_notes.size()) ? ns_notes[n0 + k] : -1, exp4[k]);
    end
    check("loop_no_done", done_cnt - d0, 0);
    pulse_stop();
    loop = 1'b0;
    check("loop_stop_playing", int'(playing), 0);

    // Stop during the gap, then restart with exact latency.
    load_vec(vecs[0]);
    n0 = ns_cnt;
    d0 = done_cnt;
    pulse_start();
    cyc = 0;
    while (!(ns_cnt > n0 && note == 0 && playing) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("gap_reached", int'(ns_cnt > n0 && note == 0 && playing), 1);
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    check("stop_note", int'(note), 0);
    check("stop_playing", int'(playing), 0);
    check("stop_rom_addr", int'(rom_addr), 0);
    repeat (40) @(posedge clk);
    #1 check("stop_no_done", done_cnt - d0, 0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart_e0_playing", int'(playing), 1);
    @(posedge clk); #1;
    check("restart_e1_note_start", int'(note_start), 0);
    @(posedge clk); #1;
    check("restart_e2_note_start", int'(note_start), 1);
    check("restart_e2_note", int'(note), 5);
    check("restart_e2_rom_addr", int'(rom_addr), 0);
    @(posedge clk); #1;
    check("note_start_one_cycle", int'(note_start), 0);
    pulse_stop();

    // Pause for 5 ticks after 2 ticks of a dur=4 note.
    for (int i = 0; i < WORDS; i++) rom[i] = '0;
    rom[0] = w(4, 4);
    n0 = ns_cnt;
    pulse_start();
    cyc = 0;
    while (!note_start && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pause_note_start_seen", int'(note_start), 1);
    base = ms_edges;
    cyc = 0;
    while (ms_edges < base + 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1 pause = 1'b1;
    check("pause_note_before", int'(note), 4);
    base = ms_edges;
    cyc = 0;
    while (ms_edges < base + 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    check("pause_hold_note", int'(note), 4);
    check("pause_hold_playing", int'(playing), 1);
    pause = 1'b0;
    base = ms_edges;
    cyc = 0;
    while (ms_edges < base + 1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    check("pause_resume_tick1_note", int'(note), 4);
    cyc = 0;
    while (ms_edges < base + 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    check("pause_resume_tick2_note", int'(note), 0);
    pulse_stop();

    // Start while playing is ignored; async reset mid-note.
    load_vec(vecs[1]);
    n0 = ns_cnt;
    pulse_start();
    cyc = 0;
    while (ns_cnt < n0 + 2 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("second_note_value", int'(note), 2);
    n0 = ns_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_start_rom_addr", int'(rom_addr), 1);
    repeat (4) @(posedge clk);
    #1 check("busy_start_no_reload", ns_cnt - n0, 0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_rst_note", int'(note), 0);
    check("async_rst_playing", int'(playing), 0);
    check("async_rst_rom_addr", int'(rom_addr), 0);
    @(posedge clk); #1 rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
